// File: rtl/gol_pkg.sv
// Shared constants and types for the Game of Life pixel cell.
package gol_pkg;

    localparam int NBR_W = 8;
    localparam int CNT_W = 4;

    // Rule masks, indexed by live-neighbour count 0..8. These values encode B3/S23.
    localparam logic [8:0] GOL_BIRTH_DEFAULT   = 9'h008;
    localparam logic [8:0] GOL_SURVIVE_DEFAULT = 9'h00C;

    typedef logic [NBR_W-1:0] nbr_t;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/gol_pixel_if.sv
// Control, neighbour and status bundle for one gol_pixel cell.
// When GOL_PIXEL_RULE_EN is defined, the bundle also carries the birth and survive masks.
interface gol_pixel_if;
    import gol_pkg::*;

    logic en;
    logic load;
    logic load_val;
    nbr_t nbr;
    logic alive;
    cnt_t nbr_cnt;
`ifdef GOL_PIXEL_RULE_EN
    logic [8:0] birth_mask;
    logic [8:0] survive_mask;

    modport master (
        output en, load, load_val, nbr, birth_mask, survive_mask,
        input  alive, nbr_cnt
    );
    modport slave (
        input  en, load, load_val, nbr, birth_mask, survive_mask,
        output alive, nbr_cnt
    );
`else
    modport master (
        output en, load, load_val, nbr,
        input  alive, nbr_cnt
    );
    modport slave (
        input  en, load, load_val, nbr,
        output alive, nbr_cnt
    );
`endif

endinterface

// File: rtl/gol_popcount8.sv
// Purely combinational population count of 8 bits, built as a 3-level adder tree.
module gol_popcount8
    import gol_pkg::*;
(
    input  nbr_t nbr,
    output cnt_t cnt
);

    logic [1:0] sum2_0, sum2_1, sum2_2, sum2_3;
    logic [2:0] sum3_0, sum3_1;

    assign sum2_0 = {1'b0, nbr[0]} + {1'b0, nbr[1]};
    assign sum2_1 = {1'b0, nbr[2]} + {1'b0, nbr[3]};
    assign sum2_2 = {1'b0, nbr[4]} + {1'b0, nbr[5]};
    assign sum2_3 = {1'b0, nbr[6]} + {1'b0, nbr[7]};

    assign sum3_0 = {1'b0, sum2_0} + {1'b0, sum2_1};
    assign sum3_1 = {1'b0, sum2_2} + {1'b0, sum2_3};

    // The final stage is 4 bits wide, so all eight neighbours alive gives 8 without wrapping.
    assign cnt = {1'b0, sum3_0} + {1'b0, sum3_1};

endmodule

// File: rtl/gol_pixel.sv
// One Game of Life cell. It applies B3/S23 by default.
// Defining GOL_PIXEL_RULE_EN takes the birth and survive masks from the bus instead.
// Priority at each edge: reset, then load, then enabled step, otherwise hold.
module gol_pixel
    import gol_pkg::*;
#(
    parameter bit INIT_ALIVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    gol_pixel_if.slave  bus
);

    cnt_t       cnt;
    logic       alive_q;
    logic       next_alive;
    logic [8:0] birth_mask;
    logic [8:0] survive_mask;

    gol_popcount8 u_popcount (
        .nbr (bus.nbr),
        .cnt (cnt)
    );

`ifdef GOL_PIXEL_RULE_EN
    assign birth_mask   = bus.birth_mask;
    assign survive_mask = bus.survive_mask;
`else
    assign birth_mask   = GOL_BIRTH_DEFAULT;
    assign survive_mask = GOL_SURVIVE_DEFAULT;
`endif

    // The next generation comes from the current state and the pre-edge neighbour count.
    always_comb begin
        next_alive = 1'b0;
        if (alive_q) begin
            next_alive = survive_mask[cnt];
        end else begin
            next_alive = birth_mask[cnt];
        end
    end

    // State register with synchronous reset. Load overrides the rule, and en gates the step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alive_q <= INIT_ALIVE;
        end else if (bus.load) begin
            alive_q <= bus.load_val;
        end else if (bus.en) begin
            alive_q <= next_alive;
        end
    end

    assign bus.alive   = alive_q;
    assign bus.nbr_cnt = cnt;

endmodule

// File: tb/tb_gol_pixel.sv
// Directed self-checking bench for gol_pixel.
// Two cells are instantiated: one with INIT_ALIVE=0 and one with INIT_ALIVE=1.
// The rule-mask checks are included when GOL_PIXEL_RULE_EN is defined.
module tb_gol_pixel;
    import gol_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    gol_pixel_if bus0 ();
    gol_pixel_if bus1 ();

    gol_pixel #(.INIT_ALIVE(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    gol_pixel #(.INIT_ALIVE(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_pop(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int b = 0; b < 8; b++) c = c + {3'd0, v[b]};
        return c;
    endfunction

    function automatic logic ref_b3s23(input logic a, input logic [7:0] v);
        logic [3:0] c;
        c = ref_pop(v);
        return (c == 4'd3) || (a && (c == 4'd2));
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Wait for one rising edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seed(input logic v);
        bus0.load = 1'b1; bus0.load_val = v; bus0.en = 1'b0;
        tick();
        bus0.load = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        bus0.en = 1'b1; bus0.load = 1'b1; bus0.load_val = 1'b1; bus0.nbr = 8'hFF;
        bus1.en = 1'b1; bus1.load = 1'b1; bus1.load_val = 1'b0; bus1.nbr = 8'hFF;
`ifdef GOL_PIXEL_RULE_EN
        bus0.birth_mask = 9'h008; bus0.survive_mask = 9'h00C;
        bus1.birth_mask = 9'h008; bus1.survive_mask = 9'h00C;
`endif
        #2;
        // Reset overrides the pending load and step, so each cell takes its INIT_ALIVE value.
        tick();
        check("reset_init0", {7'd0, bus0.alive}, 8'd0);
        check("reset_init1", {7'd0, bus1.alive}, 8'd1);
        rst_n = 1'b1;
        bus1.en = 1'b0; bus1.load = 1'b0;

        // Directed popcount boundaries.
        bus0.load = 1'b0; bus0.en = 1'b0;
        bus0.nbr = 8'h00; #1; check("cnt_00", {4'd0, bus0.nbr_cnt}, 8'd0);
        bus0.nbr = 8'h81; #1; check("cnt_81", {4'd0, bus0.nbr_cnt}, 8'd2);
        bus0.nbr = 8'hFF; #1; check("cnt_ff", {4'd0, bus0.nbr_cnt}, 8'd8);

        // Named examples from the rule table.
        seed(1'b0); bus0.nbr = 8'h07; bus0.en = 1'b1; tick();
        check("dead_07", {7'd0, bus0.alive}, 8'd1);
        seed(1'b1); bus0.nbr = 8'h03; bus0.en = 1'b1; tick();
        check("alive_03", {7'd0, bus0.alive}, 8'd1);
        seed(1'b1); bus0.nbr = 8'h01; bus0.en = 1'b1; tick();
        check("alive_01", {7'd0, bus0.alive}, 8'd0);
        seed(1'b1); bus0.nbr = 8'h0F; bus0.en = 1'b1; tick();
        check("alive_0f", {7'd0, bus0.alive}, 8'd0);

        // Exhaustive sweep over both starting states and all neighbour patterns.
        for (int a = 0; a < 2; a++) begin
            for (int n = 0; n < 256; n++) begin
                seed(a[0]);
                bus0.nbr = n[7:0];
                bus0.en  = 1'b1;
                #1;
                if (a == 0) check($sformatf("cnt_%02h", n), {4'd0, bus0.nbr_cnt}, {4'd0, ref_pop(n[7:0])});
                tick();
                check($sformatf("step_a%0d_%02h", a, n), {7'd0, bus0.alive},
                      {7'd0, ref_b3s23(a[0], n[7:0])});
            end
        end

        // With en low the cell holds its state, even when the neighbour count says die.
        seed(1'b1);
        bus0.en = 1'b0; bus0.nbr = 8'h00;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("hold_%0d", k), {7'd0, bus0.alive}, 8'd1);
        end
        bus0.en = 1'b1; tick();
        check("hold_release", {7'd0, bus0.alive}, 8'd0);

        // Load takes priority over a birth on the same edge.
        bus0.en = 1'b1; bus0.nbr = 8'h07; bus0.load = 1'b1; bus0.load_val = 1'b0;
        tick();
        check("load_beats_birth", {7'd0, bus0.alive}, 8'd0);
        bus0.load = 1'b0; tick();
        check("birth_after_load", {7'd0, bus0.alive}, 8'd1);

        // A neighbour change between enabled edges has no effect.
        bus0.en = 1'b0; bus0.nbr = 8'h00; tick();
        bus0.nbr = 8'h03; bus0.en = 1'b1; tick();
        check("sample_at_edge", {7'd0, bus0.alive}, 8'd1);

        // A mid-run reset beats a pending load to 1.
        rst_n = 1'b0; bus0.load = 1'b1; bus0.load_val = 1'b1; tick();
        check("reset_mid", {7'd0, bus0.alive}, 8'd0);
        rst_n = 1'b1; bus0.load = 1'b0;

`ifdef GOL_PIXEL_RULE_EN
        // HighLife rule (B36/S23).
        bus0.birth_mask = 9'h048; bus0.survive_mask = 9'h00C;
        seed(1'b0); bus0.nbr = 8'h3F; bus0.en = 1'b1; tick();
        check("highlife_b6", {7'd0, bus0.alive}, 8'd1);
        seed(1'b0); bus0.nbr = 8'h03; bus0.en = 1'b1; tick();
        check("highlife_b2", {7'd0, bus0.alive}, 8'd0);
        seed(1'b1); bus0.nbr = 8'h03; bus0.en = 1'b1; tick();
        check("highlife_s2", {7'd0, bus0.alive}, 8'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gol_pixel.md
Name: gol_pixel

Overview:
- One Conway's Game of Life cell (pixel) for a tiled cell array.
- Takes the eight neighbour alive bits and holds its own alive state in a register.
- Advances one generation per enabled clock edge.
- Default rule is B3/S23; a programmable birth/survive rule is available as a compile option.

Parameters:
- INIT_ALIVE, 0, alive value loaded on reset (0 = dead, 1 = alive).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  generation step enable; state holds when 0.
- load  input  1  seed strobe; overrides the rule when 1.
- load_val  input  1  value written to the cell when load=1.
- nbr  input  8  neighbour alive bits; bit0..bit7 = neighbours a..h. Ordering is irrelevant to the result.
- alive  output  1  registered cell state (the cell's out).
- nbr_cnt  output  4  combinational population count of nbr, range 0..8.

Behaviour:
- Reset: when rst_n=0 at a rising clk edge, alive <= INIT_ALIVE. nbr_cnt stays combinational and is unaffected by reset.
- Priority at each rising edge: rst_n=0 first, then load=1, then en=1, otherwise hold.
- load=1 (and rst_n=1): alive <= load_val, regardless of en or nbr.
- en=1, load=0:
  - alive <= (nbr_cnt==3) | (alive & nbr_cnt==2).
  - Birth needs exactly 3 live neighbours.
  - Survival needs 2 or 3 live neighbours.
  - Count 0,1 or 4..8 gives a dead cell next generation.
- en=0, load=0: alive holds.
- Latency: one clock from nbr sample to alive update. alive is purely registered (no combinational input-to-output path).
- nbr_cnt is a 4-bit unsigned sum of the nbr bits. 8'hFF gives 8, with no overflow.
- nbr is sampled only at the enabled edge. Neighbour changes between edges have no effect.
- Reset mid-operation overrides any pending load or step in that cycle.
- Cells in an array must update simultaneously: each cell uses its neighbours' pre-edge values.

Optional Feature:
- Macro GOL_PIXEL_RULE_EN.
- When defined, two extra input ports are added:
  - birth_mask [8:0]: bit k=1 means a dead cell with k neighbours becomes alive.
  - survive_mask [8:0]: bit k=1 means a live cell with k neighbours stays alive.
- Next state when enabled = alive ? survive_mask[nbr_cnt] : birth_mask[nbr_cnt].
- The masks are sampled on the enabled edge.
- Setting birth_mask=9'h008 and survive_mask=9'h00C reproduces B3/S23 exactly.
- When not defined, the ports are absent and the B3/S23 rule is hard-wired.

Decomposition:
- Package gol_pkg holds:
  - NBR_W=8 and CNT_W=4 constants.
  - Default rule constants: GOL_BIRTH_DEFAULT=9'h008, GOL_SURVIVE_DEFAULT=9'h00C.
  - Typedef nbr_t (logic [7:0]).
  - Typedef cnt_t (logic [3:0]).
- One sub-module, gol_popcount8: 8-bit input, 4-bit population count, purely combinational (adder tree).
- gol_pixel instantiates gol_popcount8 and adds the rule logic and state register.

Test Plan:
- Reset: INIT_ALIVE=0, hold rst_n=0 one edge with nbr=8'hFF, load=1 -> alive=0. Repeat with INIT_ALIVE=1 -> alive=1.
- Exhaustive sweep: for alive in {0,1} (set via load), drive every nbr in 0..255 with en=1, one step each -> alive matches B3/S23. Examples:
  - dead, nbr=8'h07 -> 1.
  - alive, nbr=8'h03 -> 1.
  - alive, nbr=8'h01 -> 0.
  - alive, nbr=8'h0F -> 0.
- nbr_cnt check: nbr=8'h00 -> 0; 8'h81 -> 2; 8'hFF -> 8. Verify all 256 values against a reference popcount.
- Hold: alive=1, en=0, nbr=8'h00 for 5 edges -> alive stays 1. Then en=1 -> alive=0 after one edge.
- Load priority: en=1, nbr=8'h07, load=1, load_val=0 -> alive=0 (load beats birth). Next edge with load=0 -> alive=1.
- Rule option (GOL_PIXEL_RULE_EN), HighLife masks birth_mask=9'h048, survive_mask=9'h00C:
  - dead, nbr=8'h3F (6 neighbours) -> alive=1.
  - dead, nbr=8'h03 -> alive=0.
